rt_ray_gen_stream: RTL and testbench

//  Multi-lane successor of the single-ray core: scans the image raster and emits LANES primary-ray

---
 rtl/rt_ray_gen_stream.sv | 249 ++++++++++++++++++++++++
 tb/tb_rt_ray_gen_stream.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_ray_gen_stream.sv
// rt_ray_gen_stream: raster-scanning multi-lane primary-ray generator with a credit-checked output FIFO.
// Defining RT_STALL_CNT_EN adds the stall_cycles output (backpressure cycle counter).
module rt_ray_gen_stream #(
    parameter int FP_WL           = 32,
    parameter int COORDINATE_BITS = 12,
    parameter int LANES           = 2,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    input  logic [COORDINATE_BITS-1:0]         image_width,
    input  logic [COORDINATE_BITS-1:0]         image_height,
    input  logic [3*FP_WL-1:0]                 pixel_00_loc,
    input  logic [3*FP_WL-1:0]                 pixel_delta_u,
    input  logic [3*FP_WL-1:0]                 pixel_delta_v,
    input  logic [3*FP_WL-1:0]                 camera_center,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [LANES*3*FP_WL-1:0]           m_dir,
    output logic [LANES-1:0]                   m_lane_mask,
    output logic [COORDINATE_BITS-1:0]         m_x,
    output logic [COORDINATE_BITS-1:0]         m_y,
`ifdef RT_STALL_CNT_EN
    output logic [31:0]                        stall_cycles,
`endif
    output logic                               m_last
);
    // state   | meaning
    // S_IDLE  | waiting for start; config is latched on an accepted start
    // S_RUN   | issuing beats into the pipeline while FIFO credit allows
    // S_DRAIN | last beat issued; waiting for pipeline and FIFO to empty

    localparam int CB = COORDINATE_BITS;
    localparam int VW = 3 * FP_WL;
    localparam int DW = LANES * VW;
    localparam int XW = CB + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = DW + LANES + 2 * CB + 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t state_q, state_d;

    logic [CB-1:0] width_q, height_q, cur_x_q, cur_y_q;
    logic [VW-1:0] du_q, dv_q, base_q, base_in;
    logic          zero_done_q;
    logic          accept, issue, row_end, frame_end, credit_ok, drained;
    logic [XW-1:0] x_end;
    logic [LANES-1:0] issue_mask;

    logic             s1_v_q, s1_last_q, s2_v_q, s2_last_q;
    logic [CB-1:0]    s1_x_q, s1_y_q, s2_x_q, s2_y_q;
    logic [LANES-1:0] s1_mask_q, s2_mask_q;
    logic [DW-1:0]    prod_u, s1_pu_q, s2_sum_q, sum_uv, wr_dir;
    logic [VW-1:0]    prod_v, s1_pv_q;
    logic [FP_WL-1:0] x_ext, y_ext;

    logic [PW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] head, wr_data;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fifo_count_q;
    logic          wr_en, rd_en;

    // Camera offset is constant for a frame, so it is folded in once at start.
    always_comb begin
        base_in = '0;
        for (int c = 0; c < 3; c++)
            base_in[c*FP_WL +: FP_WL] = pixel_00_loc[c*FP_WL +: FP_WL] - camera_center[c*FP_WL +: FP_WL];
    end

    assign x_end     = {1'b0, cur_x_q} + XW'(LANES);
    assign row_end   = (x_end >= {1'b0, width_q});
    assign frame_end = row_end && (cur_y_q == height_q - CB'(1));
    assign credit_ok = (int'(fifo_count_q) + int'(s1_v_q) + int'(s2_v_q)) < FIFO_DEPTH;
    assign issue     = (state_q == S_RUN) && credit_ok;
    assign drained   = (fifo_count_q == '0) && !s1_v_q && !s2_v_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = (state_q != S_IDLE);
        done    = zero_done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (image_width != '0 && image_height != '0)
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (issue && frame_end)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drained) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            zero_done_q <= 1'b0;
            width_q     <= '0;
            height_q    <= '0;
            du_q        <= '0;
            dv_q        <= '0;
            base_q      <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= accept && (image_width == '0 || image_height == '0);
            if (accept) begin
                width_q  <= image_width;
                height_q <= image_height;
                du_q     <= pixel_delta_u;
                dv_q     <= pixel_delta_v;
                base_q   <= base_in;
                cur_x_q  <= '0;
                cur_y_q  <= '0;
            end else if (issue) begin
                if (row_end) begin
                    cur_x_q <= '0;
                    cur_y_q <= cur_y_q + CB'(1);
                end else begin
                    cur_x_q <= cur_x_q + CB'(LANES);
                end
            end
        end
    end

    // Stage 1 operands: products truncated to FP_WL, coordinates zero-extended.
    always_comb begin
        prod_u     = '0;
        prod_v     = '0;
        issue_mask = '0;
        x_ext      = '0;
        y_ext      = FP_WL'(cur_y_q);
        for (int c = 0; c < 3; c++)
            prod_v[c*FP_WL +: FP_WL] = y_ext * dv_q[c*FP_WL +: FP_WL];
        for (int i = 0; i < LANES; i++) begin
            issue_mask[i] = ({1'b0, cur_x_q} + XW'(i)) < {1'b0, width_q};
            x_ext = FP_WL'(cur_x_q) + FP_WL'(i);
            for (int c = 0; c < 3; c++)
                prod_u[i*VW + c*FP_WL +: FP_WL] = x_ext * du_q[c*FP_WL +: FP_WL];
        end
    end

    always_comb begin
        sum_uv = '0;
        wr_dir = '0;
        for (int i = 0; i < LANES; i++)
            for (int c = 0; c < 3; c++) begin
                sum_uv[i*VW + c*FP_WL +: FP_WL] = s1_pu_q[i*VW + c*FP_WL +: FP_WL] + s1_pv_q[c*FP_WL +: FP_WL];
                if (s2_mask_q[i])
                    wr_dir[i*VW + c*FP_WL +: FP_WL] = s2_sum_q[i*VW + c*FP_WL +: FP_WL] + base_q[c*FP_WL +: FP_WL];
            end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_mask_q <= '0;
            s1_pu_q   <= '0;
            s1_pv_q   <= '0;
            s2_v_q    <= 1'b0;
            s2_last_q <= 1'b0;
            s2_x_q    <= '0;
            s2_y_q    <= '0;
            s2_mask_q <= '0;
            s2_sum_q  <= '0;
        end else begin
            s1_v_q    <= issue;
            s1_last_q <= issue && frame_end;
            s1_x_q    <= cur_x_q;
            s1_y_q    <= cur_y_q;
            s1_mask_q <= issue_mask;
            s1_pu_q   <= prod_u;
            s1_pv_q   <= prod_v;
            s2_v_q    <= s1_v_q;
            s2_last_q <= s1_last_q;
            s2_x_q    <= s1_x_q;
            s2_y_q    <= s1_y_q;
            s2_mask_q <= s1_mask_q;
            s2_sum_q  <= sum_uv;
        end
    end

    // Stage 3 (base add) lands directly in the FIFO entry.
    assign wr_en   = s2_v_q;
    assign wr_data = {s2_last_q, s2_y_q, s2_x_q, s2_mask_q, wr_dir};
    assign rd_en   = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (wr_en && !rd_en)
                fifo_count_q <= fifo_count_q + CNT_ONE;
            else if (rd_en && !wr_en)
                fifo_count_q <= fifo_count_q - CNT_ONE;
        end
    end

    assign m_valid = (fifo_count_q != '0);
    assign head    = mem[rd_ptr_q];
    assign {m_last, m_y, m_x, m_lane_mask, m_dir} = m_valid ? head : '0;

`ifdef RT_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            stall_q <= '0;
        else if (accept)
            stall_q <= '0;
        else if (m_valid && !m_ready && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_rt_ray_gen_stream.sv
// Bench for rt_ray_gen_stream: frame-level reference model with a per-cycle compare process.
module tb_rt_ray_gen_stream;
    localparam int FP_WL = 32;
    localparam int CB    = 12;
    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int VW    = 3 * FP_WL;
    localparam int DW    = LANES * VW;

    typedef struct packed {
        logic [DW-1:0]    dir;
        logic [LANES-1:0] mask;
        logic [CB-1:0]    x;
        logic [CB-1:0]    y;
        logic             last;
    } beat_t;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic             busy, done;
    logic [CB-1:0]    image_width = '0, image_height = '0;
    logic [VW-1:0]    pixel_00_loc = '0, pixel_delta_u = '0, pixel_delta_v = '0, camera_center = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [DW-1:0]    m_dir;
    logic [LANES-1:0] m_lane_mask;
    logic [CB-1:0]    m_x, m_y;
    logic             m_last;
`ifdef RT_STALL_CNT_EN
    logic [31:0]      stall_cycles;
`endif

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q[$];
    beat_t log_q[$];
    bit    mbusy = 0;
    bit    exp_done = 0;
    bit    prev_stall = 0;
    int    done_count = 0;
    int    stall_m = 0;
    int    ready_mode = 0;

    rt_ray_gen_stream #(.FP_WL(FP_WL), .COORDINATE_BITS(CB), .LANES(LANES), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .image_width(image_width), .image_height(image_height),
        .pixel_00_loc(pixel_00_loc), .pixel_delta_u(pixel_delta_u),
        .pixel_delta_v(pixel_delta_v), .camera_center(camera_center),
        .m_valid(m_valid), .m_ready(m_ready), .m_dir(m_dir), .m_lane_mask(m_lane_mask),
        .m_x(m_x), .m_y(m_y),
`ifdef RT_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .m_last(m_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Whole-frame expectation straight from the ray equation.
    function automatic void build_frame();
        int w, h;
        w = int'(image_width);
        h = int'(image_height);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x += LANES) begin
                beat_t b;
                logic [31:0] v;
                b = '0;
                b.x = CB'(x);
                b.y = CB'(y);
                b.last = (y == h - 1) && (x + LANES >= w);
                for (int i = 0; i < LANES; i++)
                    if (x + i < w) begin
                        b.mask[i] = 1'b1;
                        for (int c = 0; c < 3; c++) begin
                            v = pixel_00_loc[c*32 +: 32] + 32'(x + i) * pixel_delta_u[c*32 +: 32]
                              + 32'(y) * pixel_delta_v[c*32 +: 32] - camera_center[c*32 +: 32];
                            b.dir[i*VW + c*32 +: 32] = v;
                        end
                    end
                exp_q.push_back(b);
            end
    endfunction

    always @(negedge clk) begin
        bit    nxt_done, acc;
        beat_t got;
        if (!resetn) begin
            exp_q.delete();
            mbusy = 0;
            exp_done = 0;
            prev_stall = 0;
            stall_m = 0;
        end else begin
            check("busy", busy, mbusy);
            check("done", done, exp_done);
            if (done) done_count++;
            if (prev_stall) check("valid_held", m_valid, 1);
            nxt_done = 0;
            acc = start && !mbusy;
            if (exp_done) mbusy = 0;
            if (acc) begin
                stall_m = 0;
                if (image_width == 0 || image_height == 0) nxt_done = 1;
                else begin
                    mbusy = 1;
                    build_frame();
                end
            end
            if (m_valid) begin
                got.dir = m_dir;
                got.mask = m_lane_mask;
                got.x = m_x;
                got.y = m_y;
                got.last = m_last;
                if (exp_q.size() == 0) check("unexpected_valid", m_valid, 0);
                else check("beat", got, exp_q[0]);
                if (m_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    log_q.push_back(got);
                    if (m_last) nxt_done = 1;
                end
            end
            prev_stall = m_valid && !m_ready;
            if (m_valid && !m_ready) stall_m++;
            exp_done = nxt_done;
        end
    end

    initial begin
        int rc = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (rc % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            rc++;
        end
    end

    task automatic start_frame(input int w, input int h, input logic [VW-1:0] p00, input logic [VW-1:0] du,
                               input logic [VW-1:0] dv, input logic [VW-1:0] cc);
        @(posedge clk);
        #1;
        image_width = CB'(w);
        image_height = CB'(h);
        pixel_00_loc = p00;
        pixel_delta_u = du;
        pixel_delta_v = dv;
        camera_center = cc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        image_width = CB'($urandom);
        image_height = CB'($urandom);
        pixel_00_loc = {$urandom, $urandom, $urandom};
        pixel_delta_u = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input int budget);
        int n0, k;
        n0 = done_count;
        k = 0;
        while (done_count == n0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("frame_done_seen", done_count != n0, 1);
        repeat (2) @(posedge clk);
        check("leftover_beats", exp_q.size(), 0);
    endtask

    function automatic logic [VW-1:0] rvec();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        int lat;
        #12;
        check("reset_outputs", {busy, done, m_valid, m_dir, m_lane_mask, m_x, m_y, m_last}, 0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // 1: 4x2 unit deltas in Q16.16, first-beat latency
        ready_mode = 0;
        log_q.delete();
        start_frame(4, 2, '0, {32'h0, 32'h0, 32'h0001_0000}, {32'h0, 32'h0001_0000, 32'h0}, '0);
        lat = 1;
        while (!m_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("first_beat_latency", lat, 4);
        wait_done(200);
        check("t1_beats", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("t1_b1_x", log_q[1].x, 2);
            check("t1_b2_y", log_q[2].y, 1);
            check("t1_b0_last", log_q[0].last, 0);
            check("t1_b3_last", log_q[3].last, 1);
            check("t1_b3_lane1_dirx", log_q[3].dir[VW +: 32], 32'h0003_0000);
            check("t1_b3_lane1_diry", log_q[3].dir[VW+32 +: 32], 32'h0001_0000);
        end

        // 2: odd width, partial last beat
        log_q.delete();
        start_frame(3, 1, rvec(), rvec(), rvec(), rvec());
        wait_done(200);
        check("t2_beats", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t2_mask0", log_q[0].mask, 2'b11);
            check("t2_mask1", log_q[1].mask, 2'b01);
            check("t2_lane1_dir_zero", log_q[1].dir[VW +: VW], 0);
            check("t2_last", log_q[1].last, 1);
        end

        // 3: 8x8 with 1-in-3 ready
        ready_mode = 1;
        log_q.delete();
        start_frame(8, 8, rvec(), rvec(), rvec(), rvec());
        wait_done(2000);
        check("t3_beats", log_q.size(), 32);
`ifdef RT_STALL_CNT_EN
        check("t3_stall_cycles", stall_cycles, stall_m);
`endif

        // 4: wrapping product
        ready_mode = 0;
        log_q.delete();
        start_frame(4, 1, '0, {32'h0, 32'h0, 32'h7FFF_FFFF}, '0, '0);
        wait_done(200);
        if (log_q.size() == 2) begin
            check("t4_x2_wrap", log_q[1].dir[0 +: 32], 32'hFFFF_FFFE);
            check("t4_x3_wrap", log_q[1].dir[VW +: 32], 32'h7FFF_FFFD);
        end else check("t4_beats", log_q.size(), 2);

        // 5: empty frame, then start while busy
        log_q.delete();
        start_frame(0, 5, rvec(), rvec(), rvec(), rvec());
        wait_done(50);
        check("t5_no_beats", log_q.size(), 0);
        ready_mode = 2;
        start_frame(6, 3, rvec(), rvec(), rvec(), rvec());
        repeat (3) @(posedge clk);
        #1;
        image_width = 12'd2;
        image_height = 12'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(500);
        check("t5_busy_start_ignored", log_q.size(), 9);

        // random frames
        for (int n = 0; n < 8; n++) begin
            start_frame($urandom_range(0, 9), $urandom_range(0, 4), rvec(), rvec(), rvec(), rvec());
            wait_done(1000);
        end

        // 6: reset mid-frame, then a clean frame
        start_frame(8, 4, rvec(), rvec(), rvec(), rvec());
        repeat (10) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("async_reset_outputs", {busy, done, m_valid, m_dir, m_lane_mask, m_x, m_y, m_last}, 0);
`ifdef RT_STALL_CNT_EN
        check("reset_stall_cycles", stall_cycles, 0);
`endif
        @(posedge clk);
        #1 resetn = 1'b1;
        ready_mode = 0;
        log_q.delete();
        start_frame(4, 2, rvec(), rvec(), rvec(), rvec());
        wait_done(200);
        check("t6_beats", log_q.size(), 4);
        if (log_q.size() == 4) check("t6_first_xy", {log_q[0].x, log_q[0].y}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
